// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver assembling multi-byte command words
// Feeds the MDIO command stage through a one-deep valid/ready output register.
module uart_cmd_rx #(
   parameter int BaudRateDivider = 1085,
   parameter int ByteTimeout     = 24'hFFFFFF,
   parameter int NumBytes        = 4
) (
   input  logic        clk125,
   input  logic        reset_n,
   input  logic        rxd,
   output logic [31:0] cmd_data,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        frame_err,
   output logic        timeout_err,
   output logic        overrun
);

   localparam int TMAX = (BaudRateDivider > ByteTimeout) ? BaudRateDivider : ByteTimeout;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] HALF_BIT = TW'(BaudRateDivider / 2 - 1);
   localparam logic [TW-1:0] FULL_BIT = TW'(BaudRateDivider - 1);
   localparam logic [TW-1:0] GAP_TIME = TW'(ByteTimeout);
   localparam logic [2:0]    LAST_LANE = 3'(NumBytes - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   logic          sync1_q, sync1_d;
   logic          rxs_q, rxs_d;
   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    byte_cnt_q, byte_cnt_d;
   logic [31:0]   word_q, word_d;
   logic          need_high_q, need_high_d;
   logic [31:0]   cmd_data_q, cmd_data_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          timeout_err_q, timeout_err_d;
   logic          overrun_q, overrun_d;
   logic [31:0]   word_new;
   logic          word_done;
   logic          timer_zero;

   assign timer_zero = (timer_q == '0);

   always_comb begin
      sync1_d       = rxd;
      rxs_d         = sync1_q;
      state_d       = state_q;
      timer_d       = timer_zero ? timer_q : timer_q - 1'b1;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      byte_cnt_d    = byte_cnt_q;
      word_d        = word_q;
      need_high_d   = need_high_q;
      cmd_data_d    = cmd_data_q;
      cmd_valid_d   = cmd_valid_q;
      frame_err_d   = 1'b0;
      timeout_err_d = 1'b0;
      overrun_d     = 1'b0;
      word_new      = (byte_cnt_q == 3'd0) ? 32'd0 : word_q;
      word_done     = 1'b0;

      for (int i = 0; i < 4; i++) begin
         if (byte_cnt_q == 3'(i)) word_new[8*i +: 8] = shift_q;
      end

      case (state_q)
         ST_IDLE: begin
            byte_cnt_d = 3'd0;
            if (rxs_q) need_high_d = 1'b0;
            // After a framing error the line may still be low; wait for it to idle first.
            if (!rxs_q && !need_high_q) begin
               state_d = ST_START;
               timer_d = HALF_BIT;
            end
         end
         ST_START: begin
            if (timer_zero) begin
               if (rxs_q) begin
                  state_d    = ST_IDLE;
                  byte_cnt_d = 3'd0;
               end else begin
                  state_d   = ST_DATA;
                  timer_d   = FULL_BIT;
                  bit_cnt_d = 4'd8;
               end
            end
         end
         ST_DATA: begin
            if (timer_zero) begin
               shift_d   = {rxs_q, shift_q[7:1]};
               timer_d   = FULL_BIT;
               bit_cnt_d = bit_cnt_q - 4'd1;
               if (bit_cnt_q == 4'd1) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (timer_zero) begin
               if (!rxs_q) begin
                  frame_err_d = 1'b1;
                  byte_cnt_d  = 3'd0;
                  need_high_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  word_d = word_new;
                  if (byte_cnt_q == LAST_LANE) begin
                     word_done  = 1'b1;
                     byte_cnt_d = 3'd0;
                     state_d    = ST_IDLE;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 3'd1;
                     state_d    = ST_GAP;
                     timer_d    = GAP_TIME;
                  end
               end
            end
         end
         ST_GAP: begin
            if (!rxs_q) begin
               state_d = ST_START;
               timer_d = HALF_BIT;
            end else if (timer_zero) begin
               timeout_err_d = 1'b1;
               byte_cnt_d    = 3'd0;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (cmd_valid_q && cmd_ready) cmd_valid_d = 1'b0;
      if (word_done) begin
         if (!cmd_valid_q || cmd_ready) begin
            cmd_data_d  = word_new;
            cmd_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk125 or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q       <= 1'b1;
         rxs_q         <= 1'b1;
         state_q       <= ST_IDLE;
         timer_q       <= '0;
         bit_cnt_q     <= 4'd0;
         shift_q       <= 8'd0;
         byte_cnt_q    <= 3'd0;
         word_q        <= 32'd0;
         need_high_q   <= 1'b0;
         cmd_data_q    <= 32'd0;
         cmd_valid_q   <= 1'b0;
         frame_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         sync1_q       <= sync1_d;
         rxs_q         <= rxs_d;
         state_q       <= state_d;
         timer_q       <= timer_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         byte_cnt_q    <= byte_cnt_d;
         word_q        <= word_d;
         need_high_q   <= need_high_d;
         cmd_data_q    <= cmd_data_d;
         cmd_valid_q   <= cmd_valid_d;
         frame_err_q   <= frame_err_d;
         timeout_err_q <= timeout_err_d;
         overrun_q     <= overrun_d;
      end
   end

   assign cmd_data    = cmd_data_q;
   assign cmd_valid   = cmd_valid_q;
   assign frame_err   = frame_err_q;
   assign timeout_err = timeout_err_q;
   assign overrun     = overrun_q;

endmodule
